// File: rtl/div_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_if
// Description : Request/response bundle between the execute-stage ALU and the
//               iterative divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               sign;
    logic               opn_valid;
    logic               res_ready;
    logic               res_valid;
    logic [2*WIDTH-1:0] result;

    modport master (
        output a, b, sign, opn_valid, res_ready,
        input  res_valid, result
    );

    modport slave (
        input  a, b, sign, opn_valid, res_ready,
        output res_valid, result
    );
endinterface
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_seq
// Description : Radix-2 restoring divider for MIPS DIV/DIVU, result is
//               {remainder, quotient}. Optional macro: DIV_EARLY_EXIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq #(
    parameter int WIDTH = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    div_seq_if.slave    bus
);
    localparam int                 c_cnt_w   = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(WIDTH - 1);
    localparam logic [1:0]         c_st_idle = 2'd0;
    localparam logic [1:0]         c_st_calc = 2'd1;
    localparam logic [1:0]         c_st_done = 2'd2;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic               r_a_neg;
    logic               r_q_neg;
    logic               r_bypass;
    logic               r_res_valid;
    logic [2*WIDTH-1:0] r_result;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_b_zero;
    logic               w_early;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_quo_fix;

    assign w_abs_a  = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign w_abs_b  = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign w_b_zero = (bus.b == '0);

`ifdef DIV_EARLY_EXIT_EN
    assign w_early  = (w_abs_a < w_abs_b) && !w_b_zero;
`else
    assign w_early  = 1'b0;
`endif

    // One restoring step: the remainder stays below the divisor, so a passing
    // trial difference always fits in WIDTH bits.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_shift >= {1'b0, r_div});
    assign w_diff    = w_shift[WIDTH-1:0] - r_div;
    assign w_rem_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
    assign w_rem_fix = r_a_neg ? -w_rem_nxt : w_rem_nxt;
    assign w_quo_fix = r_q_neg ? -w_quo_nxt : w_quo_nxt;

    assign bus.res_valid = r_res_valid;
    assign bus.result    = r_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_a_neg     <= 1'b0;
            r_q_neg     <= 1'b0;
            r_bypass    <= 1'b0;
            r_res_valid <= 1'b0;
            r_result    <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.opn_valid) begin
                        r_state <= c_st_calc;
                        r_div   <= w_abs_b;
                        r_a_neg <= bus.sign & bus.a[WIDTH-1];
                        r_q_neg <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        // Short-cut answers spend a single cycle in CALC so the
                        // result is written one edge after accept.
                        if (w_b_zero) begin
                            r_rem    <= bus.a;
                            r_quo    <= '1;
                            r_cnt    <= c_last;
                            r_bypass <= 1'b1;
                        end else if (w_early) begin
                            r_rem    <= bus.a;
                            r_quo    <= '0;
                            r_cnt    <= c_last;
                            r_bypass <= 1'b1;
                        end else begin
                            r_rem    <= '0;
                            r_quo    <= w_abs_a;
                            r_cnt    <= '0;
                            r_bypass <= 1'b0;
                        end
                    end
                end
                c_st_calc: begin
                    if (!bus.opn_valid) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt + c_cnt_w'(1);
                        if (r_cnt == c_last) begin
                            r_state     <= c_st_done;
                            r_res_valid <= 1'b1;
                            r_result    <= r_bypass ? {r_rem, r_quo}
                                                    : {w_rem_fix, w_quo_fix};
                        end
                    end
                end
                c_st_done: begin
                    if (!bus.res_ready) begin
                        r_state     <= c_st_idle;
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
